unary_digit_collector: RTL and testbench

//  Downstream stage of the radix-9 unary adder. Counts the unary pulse train on din during each write window
//  and captures the carry flag. Converts each window to a binary digit 0..8 and assembles NUM_DIGITS digits,

---
 rtl/unary_digit_collector.sv | 237 +++++++++++++++++++++++
 tb/tb_unary_digit_collector.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/unary_digit_collector.sv
// unary_digit_collector
//   Downstream stage of the radix-(DIGIT_MAX+1) unary adder. Counts the unary
//   pulse train on din during each write window, captures the adder carry,
//   closes the window into a binary digit and assembles NUM_DIGITS digits
//   (least-significant first) into one result word for a valid/ready consumer.
//
//   Optional feature macro: UNARY_COLLECT_BIN_EN
//     When defined, an extra output result_bin carries the binary value
//     sum(digit[i] * (DIGIT_MAX+1)^i), built incrementally as digits close.
//
//   Handshake: result_valid rises with the close that fills the last slot and
//   stays high, with result/result_carry/result_bin stable, until a cycle in
//   which result_valid && result_ready; it then drops on the next cycle unless
//   that same cycle completes a new word. Acceptance ignores en.
//
//   state_dbg mirrors the window FSM (0 = read phase, 1 = write phase).
module unary_digit_collector #(
    parameter int DIGIT_MAX  = 8,
    parameter int CNT_W      = 4,
    parameter int NUM_DIGITS = 4
`ifdef UNARY_COLLECT_BIN_EN
    ,
    parameter int BIN_W      = 16
`endif
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic                        read_or_write,
    input  logic                        din,
    input  logic                        cin,
    output logic                        digit_valid,
    output logic [CNT_W-1:0]            digit,
    output logic                        digit_carry,
    output logic [NUM_DIGITS*CNT_W-1:0] result,
    output logic                        result_carry,
    output logic                        result_valid,
    input  logic                        result_ready,
    output logic                        overflow,
`ifdef UNARY_COLLECT_BIN_EN
    output logic [BIN_W-1:0]            result_bin,
`endif
    output logic                        state_dbg
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(DIGIT_MAX);

    typedef enum logic {
        S_READ  = 1'b0,
        S_WRITE = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;

    // Window bookkeeping
    logic             close_cyc;   // this en cycle closes the write window
    logic             count_en;    // this cycle carries a pulse to count
    logic             pulse_sat;   // pulse arrives with the count already at max
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_next;    // count including this cycle's pulse
    logic             flag_q;
    logic             flag_next;   // carry flag including this cycle's cin

    // Word assembly
    logic [IDX_W-1:0]      idx_q;
    logic                  slot_free;
    logic                  do_write;
    logic                  drop;
    logic                  word_done;
    logic                  accept;
    logic [NUM_DIGITS-1:0] slot_wr;

    // Window FSM: next state and per-cycle window events
    always_comb begin
        state_d   = state_q;
        close_cyc = 1'b0;
        count_en  = 1'b0;
        case (state_q)
            S_READ: begin
                if (en && read_or_write) begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (en) begin
                    // din lags the adder by one cycle, so the closing
                    // cycle still carries a pulse belonging to this window.
                    count_en = din;
                    if (!read_or_write) begin
                        close_cyc = 1'b1;
                        state_d   = S_READ;
                    end
                end
            end
            default: begin
                state_d = S_READ;
            end
        endcase
    end

    // Window FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_READ;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_dbg = state_q;

    // Saturating pulse count and carry accumulation for the current cycle
    always_comb begin
        pulse_sat = count_en && (cnt_q == MAX_CNT);
        cnt_next  = cnt_q;
        if (count_en && !pulse_sat) begin
            cnt_next = cnt_q + 1'b1;
        end
        flag_next = flag_q | (en & cin);
    end

    // Pulse counter and carry flag; both restart after every close
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            flag_q <= 1'b0;
        end else if (close_cyc) begin
            cnt_q  <= '0;
            flag_q <= 1'b0;
        end else if (en) begin
            cnt_q  <= cnt_next;
            flag_q <= flag_next;
        end
    end

    // Slot write decision: a pending, unaccepted word blocks the write
    always_comb begin
        accept    = result_valid && result_ready;
        slot_free = !result_valid || result_ready;
        do_write  = close_cyc && slot_free;
        drop      = close_cyc && !slot_free;
        word_done = do_write && (idx_q == LAST_IDX);
        slot_wr   = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (do_write && (int'(idx_q) == i)) begin
                slot_wr[i] = 1'b1;
            end
        end
    end

    // Closed-digit outputs: strobe for one cycle, value held until next close
    always_ff @(posedge clk) begin
        if (rst) begin
            digit_valid <= 1'b0;
            digit       <= '0;
            digit_carry <= 1'b0;
        end else begin
            digit_valid <= close_cyc;
            if (close_cyc) begin
                digit       <= cnt_next;
                digit_carry <= flag_next;
            end
        end
    end

    // Result word assembly, slot index and consumer handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            result       <= '0;
            result_carry <= 1'b0;
            result_valid <= 1'b0;
            idx_q        <= '0;
        end else begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (slot_wr[i]) begin
                    result[i*CNT_W +: CNT_W] <= cnt_next;
                end
            end
            if (do_write) begin
                idx_q <= (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
            end
            if (word_done) begin
                result_carry <= flag_next;
            end
            // A completing close wins over acceptance of the old word.
            if (word_done) begin
                result_valid <= 1'b1;
            end else if (accept) begin
                result_valid <= 1'b0;
            end
        end
    end

    // Sticky error: pulse beyond saturation or digit dropped on a busy word
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (pulse_sat || drop) begin
            overflow <= 1'b1;
        end
    end

`ifdef UNARY_COLLECT_BIN_EN
    localparam logic [BIN_W-1:0] RADIX = BIN_W'(DIGIT_MAX + 1);

    logic [BIN_W-1:0] acc_q;
    logic [BIN_W-1:0] weight_q;
    logic [BIN_W-1:0] base_acc;
    logic [BIN_W-1:0] base_w;
    logic [BIN_W-1:0] term;

    // Slot 0 restarts the sum with unit weight; later slots reuse the
    // running weight, which is scaled by the radix after every written digit.
    always_comb begin
        base_acc = (idx_q == '0) ? '0 : acc_q;
        base_w   = (idx_q == '0) ? BIN_W'(1) : weight_q;
        term     = BIN_W'(cnt_next) * base_w;
    end

    // Binary accumulator and running weight, advanced on each written digit
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q    <= '0;
            weight_q <= BIN_W'(1);
        end else if (do_write) begin
            acc_q    <= base_acc + term;
            weight_q <= base_w * RADIX;
        end
    end

    assign result_bin = acc_q;
`endif

endmodule

// File: tb/tb_unary_digit_collector.sv
// tb_unary_digit_collector
//   Drives directed windows and randomized phase/pulse/carry/ready traffic into
//   unary_digit_collector and compares every cycle against a reference model
//   that tallies pulses and carries per window and keeps the word as an array
//   of integer digits. Build with +define+UNARY_COLLECT_BIN_EN to also check
//   result_bin.
module tb_unary_digit_collector;

    localparam int DIGIT_MAX  = 8;
    localparam int CNT_W      = 4;
    localparam int NUM_DIGITS = 4;
    localparam int BIN_W      = 16;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;
    logic en;
    logic read_or_write;
    logic din;
    logic cin;
    logic result_ready;
    logic digit_valid;
    logic [CNT_W-1:0] digit;
    logic digit_carry;
    logic [NUM_DIGITS*CNT_W-1:0] result;
    logic result_carry;
    logic result_valid;
    logic overflow;
    logic state_dbg;
`ifdef UNARY_COLLECT_BIN_EN
    logic [BIN_W-1:0] result_bin;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    unary_digit_collector #(
        .DIGIT_MAX (DIGIT_MAX),
        .CNT_W     (CNT_W),
        .NUM_DIGITS(NUM_DIGITS)
`ifdef UNARY_COLLECT_BIN_EN
        ,
        .BIN_W     (BIN_W)
`endif
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .read_or_write(read_or_write),
        .din          (din),
        .cin          (cin),
        .digit_valid  (digit_valid),
        .digit        (digit),
        .digit_carry  (digit_carry),
        .result       (result),
        .result_carry (result_carry),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .overflow     (overflow),
`ifdef UNARY_COLLECT_BIN_EN
        .result_bin   (result_bin),
`endif
        .state_dbg    (state_dbg)
    );

    // ---------------- scoreboard / reference model ----------------
    int n_total;
    int n_bad;
    logic [CNT_W:0] exp_q[$];   // {carry, digit} per closed window

    bit m_in_write;
    int m_pulses;
    bit m_cin_seen;
    bit m_dv;
    int m_digit;
    bit m_dcarry;
    int wd[NUM_DIGITS];
    int w_idx;
    bit m_rvalid;
    bit m_rcarry;
    bit m_ovf;

    bit ready_val;
    bit gap_mode;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    task automatic model_clear();
        m_in_write = 0;
        m_pulses   = 0;
        m_cin_seen = 0;
        m_dv       = 0;
        m_digit    = 0;
        m_dcarry   = 0;
        for (int i = 0; i < NUM_DIGITS; i++) wd[i] = 0;
        w_idx    = 0;
        m_rvalid = 0;
        m_rcarry = 0;
        m_ovf    = 0;
        exp_q.delete();
    endtask

    function automatic int model_word();
        int w;
        w = 0;
        for (int i = 0; i < NUM_DIGITS; i++) w += wd[i] * (1 << (CNT_W * i));
        return w;
    endfunction

    function automatic int model_bin();
        int b;
        int wt;
        b  = 0;
        wt = 1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            b  += wd[i] * wt;
            wt *= (DIGIT_MAX + 1);
        end
        return b;
    endfunction

    task automatic compare_outputs();
        logic [CNT_W:0] e;
        check("digit_valid", 32'(digit_valid), 32'(m_dv));
        if (digit_valid) begin
            if (exp_q.size() == 0) begin
                check("dv_no_expected", 32'(digit_valid), 32'(0));
            end else begin
                e = exp_q.pop_front();
                check("sb_digit", 32'(digit), 32'(e[CNT_W-1:0]));
                check("sb_digit_carry", 32'(digit_carry), 32'(e[CNT_W]));
            end
        end
        check("digit_hold", 32'(digit), 32'(m_digit));
        check("digit_carry_hold", 32'(digit_carry), 32'(m_dcarry));
        check("result", 32'(result), 32'(model_word()));
        check("result_valid", 32'(result_valid), 32'(m_rvalid));
        check("result_carry", 32'(result_carry), 32'(m_rcarry));
        check("overflow", 32'(overflow), 32'(m_ovf));
`ifdef UNARY_COLLECT_BIN_EN
        if (m_rvalid) check("result_bin", 32'(result_bin), 32'(model_bin()));
`endif
    endtask

    // ---------------- driver tasks ----------------
    // One clock: apply inputs, advance the model by the window rules, then
    // compare the DUT 1 time unit after the edge.
    task automatic tick(input bit t_en, input bit t_rw, input bit t_din, input bit t_cin, input bit t_rdy);
        bit accepted;
        bit closing;
        bit word_done;
        int d;
        bit c;
        en            = t_en;
        read_or_write = t_rw;
        din           = t_din;
        cin           = t_cin;
        result_ready  = t_rdy;
        accepted  = m_rvalid && t_rdy;
        closing   = 0;
        word_done = 0;
        if (t_en) begin
            if (t_cin) m_cin_seen = 1;
            if (!m_in_write) begin
                if (t_rw) m_in_write = 1;
            end else begin
                if (t_din) begin
                    m_pulses++;
                    if (m_pulses > DIGIT_MAX) m_ovf = 1;
                end
                if (!t_rw) closing = 1;
            end
        end
        m_dv = closing;
        if (closing) begin
            d = (m_pulses > DIGIT_MAX) ? DIGIT_MAX : m_pulses;
            c = m_cin_seen;
            m_digit  = d;
            m_dcarry = c;
            exp_q.push_back({c, CNT_W'(d)});
            m_pulses   = 0;
            m_cin_seen = 0;
            m_in_write = 0;
            if (!m_rvalid || t_rdy) begin
                wd[w_idx] = d;
                if (w_idx == NUM_DIGITS - 1) begin
                    w_idx     = 0;
                    word_done = 1;
                    m_rcarry  = c;
                end else begin
                    w_idx++;
                end
            end else begin
                m_ovf = 1;
            end
        end
        if (word_done) m_rvalid = 1;
        else if (accepted) m_rvalid = 0;
        @(posedge clk);
        #1;
        compare_outputs();
    endtask

    // Enabled cycle, optionally preceded by a frozen (en=0) cycle of junk.
    task automatic wtick(input bit t_rw, input bit t_din, input bit t_cin);
        if (gap_mode && ($urandom_range(0, 2) == 0)) begin
            tick(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), ready_val);
        end
        tick(1'b1, t_rw, t_din, t_cin, ready_val);
    endtask

    // cin_ph: 0 none, 1 cin in the read phase, 2 cin inside the write window
    task automatic send_window(input int np, input int cin_ph);
        wtick(1'b0, 1'b0, cin_ph == 1);
        wtick(1'b0, 1'b0, 1'b0);
        wtick(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < np - 1; i++) wtick(1'b1, 1'b1, (cin_ph == 2) && (i == 0));
        wtick(1'b0, np > 0, (cin_ph == 2) && (np <= 1));
        wtick(1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        en            = 1'b0;
        read_or_write = 1'b0;
        din           = 1'b0;
        cin           = 1'b0;
        result_ready  = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
        compare_outputs();
    endtask

    // ---------------- test sequence ----------------
    initial begin
        bit rw_ph;
        n_total   = 0;
        n_bad     = 0;
        ready_val = 0;
        gap_mode  = 0;
        rst = 1'b1;
        model_clear();
        do_reset();

        // Four windows 3,5,0,8 held pending by the consumer
        send_window(3, 0);
        send_window(5, 0);
        send_window(0, 0);
        send_window(8, 0);
        check("t1_result", 32'(result), 32'h8053);
        check("t1_result_valid", 32'(result_valid), 32'(1));
        check("t1_result_carry", 32'(result_carry), 32'(0));
        check("t1_overflow", 32'(overflow), 32'(0));
`ifdef UNARY_COLLECT_BIN_EN
        check("t6_result_bin", 32'(result_bin), 32'd5880);
`endif

        // Extra window while the word is still pending: digit dropped
        send_window(2, 0);
        check("t4_digit", 32'(digit), 32'(2));
        check("t4_result_kept", 32'(result), 32'h8053);
        check("t4_overflow", 32'(overflow), 32'(1));
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("t4_accepted", 32'(result_valid), 32'(0));

        // Saturation at DIGIT_MAX, sticky overflow
        do_reset();
        ready_val = 1;
        send_window(10, 0);
        check("t3_digit_sat", 32'(digit), 32'(DIGIT_MAX));
        check("t3_overflow", 32'(overflow), 32'(1));
        send_window(2, 0);
        send_window(1, 0);
        check("t3_overflow_sticky", 32'(overflow), 32'(1));

        // Carry in read phase of digit 1 and inside window of digit 3
        do_reset();
        ready_val = 0;
        send_window(1, 0);
        send_window(2, 1);
        check("t2_digit1_carry", 32'(digit_carry), 32'(1));
        send_window(3, 0);
        check("t2_digit2_carry", 32'(digit_carry), 32'(0));
        send_window(4, 2);
        check("t2_result", 32'(result), 32'h4321);
        check("t2_result_carry", 32'(result_carry), 32'(1));

        // Reset in the middle of digit 1
        do_reset();
        send_window(1, 0);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        do_reset();
        check("t5_result_zero", 32'(result), 32'(0));
        for (int i = 0; i < 4; i++) send_window(1, 0);
        check("t5_result", 32'(result), 32'h1111);

        // Random windows with frozen en=0 cycles sprinkled in
        do_reset();
        gap_mode  = 1;
        ready_val = 1;
        for (int i = 0; i < 12; i++) begin
            send_window($urandom_range(0, DIGIT_MAX + 1), $urandom_range(0, 2));
        end
        gap_mode = 0;

        // Fully random traffic
        for (int r = 0; r < 4; r++) begin
            do_reset();
            rw_ph = 0;
            for (int c = 0; c < 600; c++) begin
                if ($urandom_range(0, 3) == 0) rw_ph = ~rw_ph;
                tick(1'($urandom_range(0, 3) != 0), rw_ph, 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)));
            end
        end

        check("exp_q_drained", 32'(exp_q.size()), 32'(0));
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
